line_bresenham_stepper: RTL
===========================

// Module: line_bresenham_stepper
// PURPOSE
//  Consumes one captured line, i.e. line_cap_reg plus the dx/dy produced by the steep calculator, and walks it with
//  integer Bresenham stepping. Emits one pixel per accepted output beat, from (x0,y0) to (x1,y1) inclusive.
//  Sits between the steep calculator and the pixel/framebuffer write path.
//  Ready/valid on both sides; one line in flight at a time.
// PARAMETERS
//  COORD_W   10  coordinate width; dx/dy are COORD_W+1 bits, two's complement
//  ATTR_W     6  per-line attribute bits (line_cap_reg[ATTR_W-1:0]), passed through to every pixel
// PORTS
//  clk          in   1              rising-edge clock
//  rst_n        in   1              synchronous active-low reset
//  line_cap_reg in   4*COORD_W+ATTR_W  {x0,y0,x1,y1,attr}, x0 in MSBs (46 bits at defaults)
//  dx           in   COORD_W+1      x1-x0, two's complement
//  dy           in   COORD_W+1      y1-y0, two's complement
//  line_valid   in   1              line_cap_reg/dx/dy valid
//  line_ready   out  1              block can accept a line (IDLE only)
//  px_x         out  COORD_W        current pixel x
//  px_y         out  COORD_W        current pixel y
//  px_attr      out  ATTR_W         attr of the current line
//  px_valid     out  1              pixel beat valid
//  px_ready     in   1              downstream accepts the beat
//  px_last      out  1              qualifies the final pixel of the line
//  line_done    out  1              1-cycle pulse, cycle after last pixel accepted
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0. line_ready=1 from the first cycle after release.
//  Reset mid-line: the line is abandoned, with no line_done and no further pixels.
//  FSM IDLE -> SETUP -> DRAW -> IDLE:
//   IDLE:  line_ready=1. On line_valid&line_ready, latch x0,y0,attr,dx,dy and go to SETUP.
//   SETUP: adx=|dx|, ady=|dy| (COORD_W bits). sx=dx[MSB]?-1:+1, sy likewise.
//          ymaj = (ady>adx); a tie is x-major. maj/min = larger/smaller of adx,ady.
//          err = 2*min - maj, signed COORD_W+3 bits. cnt=maj. Load cur=(x0,y0). Go to DRAW.
//   DRAW:  px_valid=1, px_x/px_y=cur, px_last=(cnt==0).
//          Outputs stay stable while px_valid&!px_ready.
//          On px_valid&px_ready with cnt!=0:
//            step the major axis by its sign;
//            if err>0: also step the minor axis, err += 2*(min-maj);
//            else: err += 2*min;
//            cnt -= 1.
//          On acceptance with cnt==0: go to IDLE, px_valid=0, line_done=1 for exactly one cycle.
//  Latency: line accepted at edge N; first px_valid at N+2; at most one pixel per cycle thereafter.
//  Pixel count = max(|dx|,|dy|)+1. Zero-length line (dx=dy=0): one pixel with px_last=1.
//  Coordinates never leave [min(x0,x1),max(x0,x1)] x [min(y0,y1),max(y0,y1)], so no wrap-around.
//  The final pixel equals (x1,y1) exactly.
//  dx/dy are trusted to match the endpoints; x1/y1 are not otherwise used.
//  Extremes: |dx| or |dy| up to 2^COORD_W-1; err must not overflow.
//  line_valid is ignored outside IDLE. line_ready drops the cycle after acceptance.
// TESTING
//  T1 horizontal (0,0)->(5,0), px_ready=1: pixels x=0..5, y=0; px_last on the 6th; line_done 1 cycle later.
//  T2 steep negative (10,10)->(8,15), dx=-2, dy=5:
//     (10,10),(10,11),(9,12),(9,13),(8,14),(8,15), last on (8,15).
//  T3 diagonal tie (3,3)->(0,0): x-major; (3,3),(2,2),(1,1),(0,0).
//  T4 point (7,7)->(7,7), attr=6'h2A: single beat (7,7), px_attr=2A, px_last=1.
//  T5 backpressure on T1 (px_ready toggling 1,0,0,1...): same 6 pixels, no drops or duplicates,
//     outputs stable while stalled; line_valid asserted during DRAW is not accepted.
//  T6 reset mid T1 after 3 pixels: all outputs 0, no line_done; line_ready=1 next cycle;
//     a new line (0,0)->(1023,1023) then emits 1024 pixels ending at (1023,1023).

Source files
------------

// File: rtl/line_bresenham_stepper.sv
// Walks one captured line with integer Bresenham stepping, emitting one pixel per
// accepted ready/valid beat from (x0,y0) to (x1,y1) inclusive.
module line_bresenham_stepper #(
   parameter int COORD_W = 10,
   parameter int ATTR_W  = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [4*COORD_W+ATTR_W-1:0]   line_cap_reg,
   input  logic [COORD_W:0]              dx,
   input  logic [COORD_W:0]              dy,
   input  logic                          line_valid,
   output logic                          line_ready,
   output logic [COORD_W-1:0]            px_x,
   output logic [COORD_W-1:0]            px_y,
   output logic [ATTR_W-1:0]             px_attr,
   output logic                          px_valid,
   input  logic                          px_ready,
   output logic                          px_last,
   output logic                          line_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_DRAW  = 2'd2;

   localparam int ERR_W  = COORD_W + 3;
   localparam int X0_LSB = 3*COORD_W + ATTR_W;
   localparam int Y0_LSB = 2*COORD_W + ATTR_W;

   logic [1:0]              r_state;
   logic                    r_armed;
   logic [COORD_W-1:0]      r_x;
   logic [COORD_W-1:0]      r_y;
   logic [ATTR_W-1:0]       r_attr;
   logic [COORD_W:0]        r_dx;
   logic [COORD_W:0]        r_dy;
   logic                    r_ymaj;
   logic [COORD_W-1:0]      r_maj;
   logic [COORD_W-1:0]      r_min;
   logic [COORD_W-1:0]      r_cnt;
   logic signed [ERR_W-1:0] r_err;
   logic                    r_done;

   logic [COORD_W:0]        w_dx_abs;
   logic [COORD_W:0]        w_dy_abs;
   logic [COORD_W-1:0]      w_adx;
   logic [COORD_W-1:0]      w_ady;
   logic                    w_ymaj;
   logic [COORD_W-1:0]      w_maj;
   logic [COORD_W-1:0]      w_min;
   logic signed [ERR_W-1:0] w_err_init;
   logic signed [ERR_W-1:0] w_two_min;
   logic signed [ERR_W-1:0] w_two_maj;
   logic                    w_step_min;
   logic [COORD_W-1:0]      w_x_step;
   logic [COORD_W-1:0]      w_y_step;
   logic                    w_unused;

   // x1/y1 are implied by dx/dy and deliberately ignored.
   assign w_unused = ^line_cap_reg[Y0_LSB-1:ATTR_W];

   assign w_dx_abs   = r_dx[COORD_W] ? -r_dx : r_dx;
   assign w_dy_abs   = r_dy[COORD_W] ? -r_dy : r_dy;
   assign w_adx      = w_dx_abs[COORD_W-1:0];
   assign w_ady      = w_dy_abs[COORD_W-1:0];
   assign w_ymaj     = (w_ady > w_adx);
   assign w_maj      = w_ymaj ? w_ady : w_adx;
   assign w_min      = w_ymaj ? w_adx : w_ady;
   assign w_err_init = signed'({2'b00, w_min, 1'b0}) - signed'({3'b000, w_maj});

   assign w_two_min  = signed'({2'b00, r_min, 1'b0});
   assign w_two_maj  = signed'({2'b00, r_maj, 1'b0});
   assign w_step_min = !r_err[ERR_W-1] && (r_err != '0);
   assign w_x_step   = r_dx[COORD_W] ? r_x - COORD_W'(1) : r_x + COORD_W'(1);
   assign w_y_step   = r_dy[COORD_W] ? r_y - COORD_W'(1) : r_y + COORD_W'(1);

   assign line_ready = (r_state == S_IDLE) && r_armed;
   assign px_valid   = (r_state == S_DRAW);
   assign px_last    = px_valid && (r_cnt == '0);
   assign px_x       = r_x;
   assign px_y       = r_y;
   assign px_attr    = r_attr;
   assign line_done  = r_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_armed <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_attr  <= '0;
         r_dx    <= '0;
         r_dy    <= '0;
         r_ymaj  <= 1'b0;
         r_maj   <= '0;
         r_min   <= '0;
         r_cnt   <= '0;
         r_err   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Start point goes straight into the pixel registers; px_valid is low until DRAW.
               if (line_valid && r_armed) begin
                  r_x     <= line_cap_reg[X0_LSB +: COORD_W];
                  r_y     <= line_cap_reg[Y0_LSB +: COORD_W];
                  r_attr  <= line_cap_reg[ATTR_W-1:0];
                  r_dx    <= dx;
                  r_dy    <= dy;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_ymaj  <= w_ymaj;
               r_maj   <= w_maj;
               r_min   <= w_min;
               r_err   <= w_err_init;
               r_cnt   <= w_maj;
               r_state <= S_DRAW;
            end
            S_DRAW: begin
               if (px_ready) begin
                  if (r_cnt == '0) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     if (r_ymaj) begin
                        r_y <= w_y_step;
                        if (w_step_min) r_x <= w_x_step;
                     end else begin
                        r_x <= w_x_step;
                        if (w_step_min) r_y <= w_y_step;
                     end
                     r_err <= w_step_min ? r_err + w_two_min - w_two_maj : r_err + w_two_min;
                     r_cnt <= r_cnt - COORD_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
